// File: rtl/adder_tree_scheduler.sv
// Job scheduler for an external pipelined adder tree: feeds beats into the tree,
// tracks in-flight beats with a valid shift register and accumulates root sums.
module adder_tree_scheduler #(
  parameter int unsigned DATA_BITWIDTH   = 8,
  parameter int unsigned BREADTH_OF_TREE = 32,
  parameter int unsigned TREE_LATENCY    = 6,
  parameter int unsigned ACC_BITWIDTH    = 16
) (
  input  logic                                     clk,
  input  logic                                     rstN,
  input  logic                                     start,
  input  logic [7:0]                               cfg_beats,
  input  logic                                     abort,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [DATA_BITWIDTH*BREADTH_OF_TREE-1:0] in_data,
  output logic [DATA_BITWIDTH*BREADTH_OF_TREE-1:0] tree_din,
  input  logic [DATA_BITWIDTH-1:0]                 tree_sum,
  output logic                                     res_valid,
  input  logic                                     res_ready,
  output logic [ACC_BITWIDTH-1:0]                  res_data,
  output logic                                     res_ovf,
  output logic                                     busy
);

  localparam int unsigned VEC_W   = DATA_BITWIDTH * BREADTH_OF_TREE;
  localparam int unsigned BEATS_W = 8;
  localparam int unsigned SUM_W   = ACC_BITWIDTH + 1;
  localparam logic [TREE_LATENCY-1:0] SR_LAST = {1'b1, {(TREE_LATENCY-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

  state_e                    state_q, state_d;
  logic [BEATS_W-1:0]        beats_left_q, beats_left_d;
  logic [TREE_LATENCY-1:0]   sr_q, sr_d;
  logic [ACC_BITWIDTH-1:0]   acc_q, acc_d;
  logic                      ovf_q, ovf_d;
  logic                      in_ready_q, in_ready_d;
  logic                      res_valid_q, res_valid_d;
  logic                      busy_q, busy_d;
  logic                      fire_c;
  logic [SUM_W-1:0]          acc_sum_c;

  assign fire_c    = in_valid & in_ready_q;
  assign tree_din  = fire_c ? in_data : VEC_W'(0);
  assign acc_sum_c = {1'b0, acc_q} + SUM_W'(tree_sum);

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = acc_q;
  assign res_ovf   = ovf_q;
  assign busy      = busy_q;

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    sr_d         = {sr_q[TREE_LATENCY-2:0], fire_c};
    acc_d        = acc_q;
    ovf_d        = ovf_q;

    // The top shift-register bit marks tree_sum as belonging to an accepted beat.
    if (sr_q[TREE_LATENCY-1]) begin
      acc_d = acc_sum_c[ACC_BITWIDTH-1:0];
      ovf_d = ovf_q | acc_sum_c[ACC_BITWIDTH];
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d        = '0;
          ovf_d        = 1'b0;
          sr_d         = '0;
          beats_left_d = cfg_beats;
          state_d      = (cfg_beats == BEATS_W'(0)) ? DONE : FEED;
        end
      end
      FEED: begin
        if (fire_c) begin
          beats_left_d = beats_left_q - BEATS_W'(1);
          if (beats_left_q == BEATS_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (sr_q == SR_LAST) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over fire and res_ready; clearing sr_d keeps tree residue out of acc.
    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      sr_d         = '0;
      beats_left_d = beats_left_q;
    end

    in_ready_d  = (state_d == FEED);
    res_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      sr_q         <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      sr_q         <= sr_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      in_ready_q   <= in_ready_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_adder_tree_scheduler.sv
// Scoreboard bench for adder_tree_scheduler with a behavioural pipelined adder tree.
module tb_adder_tree_scheduler;

  localparam int unsigned DW    = 8;
  localparam int unsigned BT    = 32;
  localparam int unsigned TL    = 6;
  localparam int unsigned AW    = 12;
  localparam int unsigned VEC_W = DW * BT;

  logic             clk = 1'b0;
  logic             rstN;
  logic             start;
  logic [7:0]       cfg_beats;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] in_data;
  logic [VEC_W-1:0] tree_din;
  logic [DW-1:0]    tree_sum;
  logic             res_valid;
  logic             res_ready;
  logic [AW-1:0]    res_data;
  logic             res_ovf;
  logic             busy;

  typedef struct packed {
    logic [AW-1:0] data;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  adder_tree_scheduler #(
    .DATA_BITWIDTH(DW), .BREADTH_OF_TREE(BT), .TREE_LATENCY(TL), .ACC_BITWIDTH(AW)
  ) dut (
    .clk(clk), .rstN(rstN), .start(start), .cfg_beats(cfg_beats), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .tree_din(tree_din),
    .tree_sum(tree_sum), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lane_sum(input logic [VEC_W-1:0] d);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < int'(BT); i++) s = s + d[i*DW +: DW];
    return s;
  endfunction

  function automatic logic [VEC_W-1:0] fill(input logic [DW-1:0] v);
    logic [VEC_W-1:0] r;
    for (int i = 0; i < int'(BT); i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  // Tree model: samples tree_din on the accepting edge, root valid TL-1 edges later; never reset.
  logic [DW-1:0] pipe [TL] = '{default: '0};
  always @(posedge clk) begin
    pipe[0] <= lane_sum(tree_din);
    for (int k = 1; k < int'(TL); k++) pipe[k] <= pipe[k-1];
  end
  assign tree_sum = pipe[TL-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstN && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_data", 32'(res_data), 32'(e.data));
        chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
      end
    end
  end

  task automatic start_job(input logic [7:0] n);
    start = 1'b1;
    cfg_beats = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] v);
    int t;
    in_data  = fill(v);
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) chk("beat_timeout", 32'(t), 32'(0));
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!res_valid && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) chk("result_timeout", 32'(n), 32'(0));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'(0));
    chk({tag, "_res_data"}, 32'(res_data), 32'(0));
    chk({tag, "_res_ovf"}, 32'(res_ovf), 32'(0));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_tree_din_zero"}, 32'(tree_din == '0), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstN = 1'b0; start = 1'b0; cfg_beats = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; res_ready = 1'b1;
    #3;
    reset_checks("rst");
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk); #1;

    // One beat of ones: 32; acc edge is TL edges after the accepting edge (TL+1 counting it).
    exp_q.push_back('{data: AW'(32), ovf: 1'b0});
    start_job(8'd1);
    send_beat(8'd1);
    wait_result(n);
    chk("latency_edges_after_accept", 32'(n), 32'(TL));
    @(posedge clk); #1;

    // Four beats 1..4 with 3-cycle gaps: 32*(1+2+3+4) = 320.
    exp_q.push_back('{data: AW'(320), ovf: 1'b0});
    start_job(8'd4);
    for (int v = 1; v <= 4; v++) begin
      send_beat(DW'(v));
      repeat (3) begin @(posedge clk); #1; end
    end
    wait_result(n);
    @(posedge clk); #1;

    // Empty job: DONE right after the start edge, nothing ever offered.
    exp_q.push_back('{data: AW'(0), ovf: 1'b0});
    start_job(8'd0);
    chk("zero_res_valid", 32'(res_valid), 32'(1));
    chk("zero_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    chk("zero_back_idle", 32'(busy), 32'(0));

    // Abort after two of four beats, then a fresh 1-beat job of twos: 64.
    start_job(8'd4);
    send_beat(8'd5);
    send_beat(8'd5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_in_ready", 32'(in_ready), 32'(0));
    chk("abort_res_valid", 32'(res_valid), 32'(0));
    exp_q.push_back('{data: AW'(64), ovf: 1'b0});
    start_job(8'd1);
    send_beat(8'd2);
    wait_result(n);
    @(posedge clk); #1;

    // Back-pressure in DONE: result held for 10 cycles while start is ignored.
    res_ready = 1'b0;
    exp_q.push_back('{data: AW'(96), ovf: 1'b0});
    start_job(8'd1);
    send_beat(8'd3);
    wait_result(n);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      cfg_beats = 8'd5;
      @(posedge clk); #1;
      start = 1'b0;
      chk("hold_res_data", 32'(res_data), 32'(96));
      chk("hold_res_valid", 32'(res_valid), 32'(1));
    end
    chk("hold_in_ready", 32'(in_ready), 32'(0));
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_busy", 32'(busy), 32'(0));
    chk("release_res_valid", 32'(res_valid), 32'(0));

    // 255 beats of sevens (224 each): 57120 mod 4096 = 3872 with wrap flag.
    exp_q.push_back('{data: AW'(3872), ovf: 1'b1});
    start_job(8'd255);
    for (int b = 0; b < 255; b++) send_beat(8'd7);
    wait_result(n);
    @(posedge clk); #1;

    // Reset mid-job, then a clean job despite residue in the tree.
    start_job(8'd2);
    send_beat(8'd9);
    rstN = 1'b0;
    #1;
    reset_checks("midrst");
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{data: AW'(32), ovf: 1'b0});
    start_job(8'd1);
    send_beat(8'd1);
    wait_result(n);
    @(posedge clk); #1;

    repeat (5) begin @(posedge clk); #1; end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
